pc_redirect_seq: RTL and testbench

- Owns the 8-bit program counter and sequences fetch redirection around the jump/branch resolution unit.
- Consumes SEL, BRANCH_ADDR and JUMP_ADDR from jump/branch control.
- Drives PC update, IF/ID write enable and per-stage flushes.
- Inserts load-use stalls for ID-resolved register branches/jumps (jr, ber, bner) and holds fetch for a programmable boot window after reset.

---
 rtl/pc_redirect_seq.sv | 162 ++++++++++++++++
 tb/tb_pc_redirect_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_seq.sv
// Program counter owner and fetch redirect sequencer.
// Handles boot hold, MEM/ID redirects and load-use bubbles for ID-resolved branches.
module pc_redirect_seq #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned LOAD_STALL  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HOLD,
    input  logic [1:0] SEL,
    input  logic [7:0] BRANCH_ADDR,
    input  logic [7:0] JUMP_ADDR,
    input  logic [4:0] IFID_OPCODE,
    input  logic [3:0] IFID_SRC_ADDR,
    input  logic [4:0] IDEX_OPCODE,
    input  logic [3:0] IDEX_DEST_ADDR,
    input  logic [4:0] EXMEM_OPCODE,
    output logic [7:0] PC,
    output logic       PC_WE,
    output logic       IFID_WE,
    output logic       IFID_FLUSH,
    output logic       IDEX_FLUSH,
    output logic       EXMEM_FLUSH,
    output logic [7:0] REDIRECT_CNT,
    output logic [7:0] STALL_CNT
);

    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_BE   = 5'b10100;
    localparam logic [4:0] OP_BNER = 5'b10101;
    localparam logic [4:0] OP_BER  = 5'b10110;
    localparam logic [4:0] OP_J    = 5'b10111;
    localparam logic [4:0] OP_JR   = 5'b11000;
    localparam logic [4:0] OP_LD   = 5'b11010;

    localparam logic [3:0] BOOT_LAST =
        (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);
    localparam logic [1:0] STALL_LAST = 2'(LOAD_STALL - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [3:0] boot_q, boot_d;
    logic [1:0] stl_q, stl_d;
    logic [7:0] redir_q, redir_d;
    logic [7:0] scnt_q, scnt_d;

    logic       take;
    logic [7:0] target;
    logic       id_br;
    logic       mem_redir;
    logic       hazard;

    assign take      = (SEL == 2'd1) || (SEL == 2'd2);
    assign target    = (SEL == 2'd1) ? BRANCH_ADDR : JUMP_ADDR;
    assign id_br     = (IFID_OPCODE == OP_JR) || (IFID_OPCODE == OP_BER)
                     || (IFID_OPCODE == OP_BNER);
    assign mem_redir = take && ((EXMEM_OPCODE == OP_J)
                     || (EXMEM_OPCODE == OP_BE) || (EXMEM_OPCODE == OP_BNE));
    assign hazard    = id_br && (IDEX_OPCODE == OP_LD)
                     && (IDEX_DEST_ADDR == IFID_SRC_ADDR);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        boot_d      = boot_q;
        stl_d       = stl_q;
        redir_d     = redir_q;
        scnt_d      = scnt_q;
        PC_WE       = 1'b0;
        IFID_WE     = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                IFID_FLUSH  = 1'b1;
                IDEX_FLUSH  = 1'b1;
                EXMEM_FLUSH = 1'b1;
                if (!HOLD) begin
                    if (boot_q == BOOT_LAST) begin
                        state_d = S_RUN;
                        boot_d  = 4'd0;
                    end else begin
                        boot_d = boot_q + 4'd1;
                    end
                end
            end
            S_RUN, S_STALL: begin
                if (HOLD) begin
                    state_d = state_q;
                end else if (mem_redir) begin
                    // MEM-stage redirect wins and abandons any pending stall
                    PC_WE       = 1'b1;
                    IFID_WE     = 1'b1;
                    IFID_FLUSH  = 1'b1;
                    IDEX_FLUSH  = 1'b1;
                    EXMEM_FLUSH = 1'b1;
                    pc_d        = target;
                    redir_d     = redir_q + 8'd1;
                    state_d     = S_RUN;
                end else if (state_q == S_STALL) begin
                    IDEX_FLUSH = 1'b1;
                    scnt_d     = scnt_q + 8'd1;
                    stl_d      = stl_q + 2'd1;
                    if (stl_q == STALL_LAST) begin
                        state_d = S_RUN;
                    end
                end else if (hazard) begin
                    IDEX_FLUSH = 1'b1;
                    scnt_d     = scnt_q + 8'd1;
                    if (LOAD_STALL > 1) begin
                        state_d = S_STALL;
                        stl_d   = 2'd1;
                    end
                end else if (id_br && take) begin
                    PC_WE      = 1'b1;
                    IFID_WE    = 1'b1;
                    IFID_FLUSH = 1'b1;
                    pc_d       = target;
                    redir_d    = redir_q + 8'd1;
                end else begin
                    PC_WE   = 1'b1;
                    IFID_WE = 1'b1;
                    pc_d    = pc_q + 8'd1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            boot_q  <= 4'd0;
            stl_q   <= 2'd0;
            redir_q <= 8'd0;
            scnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            boot_q  <= boot_d;
            stl_q   <= stl_d;
            redir_q <= redir_d;
            scnt_q  <= scnt_d;
        end
    end

    assign PC           = pc_q;
    assign REDIRECT_CNT = redir_q;
    assign STALL_CNT    = scnt_q;

endmodule

// File: tb/tb_pc_redirect_seq.sv
// Bench for pc_redirect_seq: directed table, hand sequences, and
// randomized stimulus against a behavioural model.
module tb_pc_redirect_seq;

    localparam logic [7:0] RPC  = 8'h10;
    localparam int         BOOT = 2;
    localparam int         LS   = 2;

    localparam logic [4:0] NOP     = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_BE   = 5'b10100;
    localparam logic [4:0] OP_BNER = 5'b10101;
    localparam logic [4:0] OP_BER  = 5'b10110;
    localparam logic [4:0] OP_J    = 5'b10111;
    localparam logic [4:0] OP_JR   = 5'b11000;
    localparam logic [4:0] OP_LD   = 5'b11010;
    localparam logic [4:0] POOL [8] = '{NOP, OP_BNE, OP_BE, OP_BNER,
                                        OP_BER, OP_J, OP_JR, OP_LD};

    logic       CLK, RST, HOLD;
    logic [1:0] SEL;
    logic [7:0] BRANCH_ADDR, JUMP_ADDR;
    logic [4:0] IFID_OPCODE, IDEX_OPCODE, EXMEM_OPCODE;
    logic [3:0] IFID_SRC_ADDR, IDEX_DEST_ADDR;
    logic [7:0] PC, REDIRECT_CNT, STALL_CNT;
    logic       PC_WE, IFID_WE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH;

    pc_redirect_seq #(
        .RESET_PC   (RPC),
        .BOOT_CYCLES(BOOT),
        .LOAD_STALL (LS)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .HOLD          (HOLD),
        .SEL           (SEL),
        .BRANCH_ADDR   (BRANCH_ADDR),
        .JUMP_ADDR     (JUMP_ADDR),
        .IFID_OPCODE   (IFID_OPCODE),
        .IFID_SRC_ADDR (IFID_SRC_ADDR),
        .IDEX_OPCODE   (IDEX_OPCODE),
        .IDEX_DEST_ADDR(IDEX_DEST_ADDR),
        .EXMEM_OPCODE  (EXMEM_OPCODE),
        .PC            (PC),
        .PC_WE         (PC_WE),
        .IFID_WE       (IFID_WE),
        .IFID_FLUSH    (IFID_FLUSH),
        .IDEX_FLUSH    (IDEX_FLUSH),
        .EXMEM_FLUSH   (EXMEM_FLUSH),
        .REDIRECT_CNT  (REDIRECT_CNT),
        .STALL_CNT     (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       hold;
        logic [1:0] sel;
        logic [7:0] ba;
        logic [7:0] ja;
        logic [4:0] ifop;
        logic [3:0] ifsrc;
        logic [4:0] idop;
        logic [3:0] iddst;
        logic [4:0] exop;
        logic [4:0] ctl;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl [12];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {PC_WE, IFID_WE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH};
    endfunction

    function automatic vec_t mkv(logic h, logic [1:0] s, logic [7:0] ba,
                                 logic [7:0] ja, logic [4:0] ifop,
                                 logic [3:0] ifsrc, logic [4:0] idop,
                                 logic [3:0] iddst, logic [4:0] exop);
        vec_t v;
        v = '{h, s, ba, ja, ifop, ifsrc, idop, iddst, exop, 5'd0, 8'd0};
        return v;
    endfunction

    task automatic drive(vec_t v);
        HOLD           = v.hold;
        SEL            = v.sel;
        BRANCH_ADDR    = v.ba;
        JUMP_ADDR      = v.ja;
        IFID_OPCODE    = v.ifop;
        IFID_SRC_ADDR  = v.ifsrc;
        IDEX_OPCODE    = v.idop;
        IDEX_DEST_ADDR = v.iddst;
        EXMEM_OPCODE   = v.exop;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Behavioural model: boot and bubbles tracked as remaining-cycle counts
    logic [7:0] m_pc, m_redir, m_stall, n_pc, n_redir, n_stall;
    int         m_boot, m_bub, n_boot, n_bub;
    logic [4:0] e_ctl;

    task automatic model_reset();
        m_pc    = RPC;
        m_redir = 8'd0;
        m_stall = 8'd0;
        m_boot  = (BOOT > 0) ? BOOT : 1;
        m_bub   = 0;
    endtask

    task automatic model_eval();
        logic       take, is_id, mem, haz;
        logic [7:0] tgt;
        take  = (SEL == 2'd1) || (SEL == 2'd2);
        tgt   = (SEL == 2'd1) ? BRANCH_ADDR : JUMP_ADDR;
        is_id = IFID_OPCODE inside {OP_JR, OP_BER, OP_BNER};
        mem   = take && (EXMEM_OPCODE inside {OP_J, OP_BE, OP_BNE});
        haz   = is_id && IDEX_OPCODE == OP_LD
              && IDEX_DEST_ADDR == IFID_SRC_ADDR;
        n_pc = m_pc; n_redir = m_redir; n_stall = m_stall;
        n_boot = m_boot; n_bub = m_bub;
        e_ctl = 5'b00000;
        if (m_boot > 0) begin
            e_ctl = 5'b00111;
            if (!HOLD) n_boot = m_boot - 1;
        end else if (HOLD) begin
            e_ctl = 5'b00000;
        end else if (mem) begin
            e_ctl = 5'b11111; n_pc = tgt; n_redir = m_redir + 8'd1; n_bub = 0;
        end else if (m_bub > 0) begin
            e_ctl = 5'b00010; n_stall = m_stall + 8'd1; n_bub = m_bub - 1;
        end else if (haz) begin
            e_ctl = 5'b00010; n_stall = m_stall + 8'd1; n_bub = LS - 1;
        end else if (is_id && take) begin
            e_ctl = 5'b11100; n_pc = tgt; n_redir = m_redir + 8'd1;
        end else begin
            e_ctl = 5'b11000; n_pc = m_pc + 8'd1;
        end
    endtask

    task automatic model_commit();
        m_pc = n_pc; m_redir = n_redir; m_stall = n_stall;
        m_boot = n_boot; m_bub = n_bub;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 8'h00, 8'h00, NOP,     0, NOP,   0, NOP,    5'b11000, 8'h11};
        tbl[1]  = '{0, 1, 8'h00, 8'h00, NOP,     0, NOP,   0, NOP,    5'b11000, 8'h12};
        tbl[2]  = '{0, 2, 8'h00, 8'h5A, NOP,     0, NOP,   0, OP_J,   5'b11111, 8'h5A};
        tbl[3]  = '{0, 2, 8'h00, 8'h33, OP_JR,   0, NOP,   0, NOP,    5'b11100, 8'h33};
        tbl[4]  = '{0, 0, 8'h40, 8'h00, NOP,     0, NOP,   0, OP_BE,  5'b11000, 8'h34};
        tbl[5]  = '{0, 1, 8'h40, 8'h00, OP_JR,   0, NOP,   0, OP_BE,  5'b11111, 8'h40};
        tbl[6]  = '{1, 2, 8'h00, 8'h99, NOP,     0, NOP,   0, OP_J,   5'b00000, 8'h40};
        tbl[7]  = '{0, 3, 8'h00, 8'h00, OP_BER,  0, NOP,   0, NOP,    5'b11000, 8'h41};
        tbl[8]  = '{0, 1, 8'h77, 8'h00, OP_BNER, 0, NOP,   0, NOP,    5'b11100, 8'h77};
        tbl[9]  = '{0, 1, 8'hFF, 8'h00, OP_JR,   3, OP_LD, 3, OP_BNE, 5'b11111, 8'hFF};
        tbl[10] = '{0, 0, 8'h00, 8'h00, NOP,     0, NOP,   0, NOP,    5'b11000, 8'h00};
        tbl[11] = '{0, 0, 8'h00, 8'h00, OP_JR,   3, OP_LD, 2, NOP,    5'b11000, 8'h01};

        RST = 1'b1;
        drive(mkv(0, 0, 0, 0, NOP, 0, NOP, 0, NOP));
        #1;
        check("reset_pc", PC, RPC);
        check("reset_redir", REDIRECT_CNT, 0);
        check("reset_stall", STALL_CNT, 0);
        check("reset_ctl", ctl_now(), 5'b00111);

        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < BOOT; i++) begin
            #1;
            check($sformatf("boot%0d_ctl", i), ctl_now(), 5'b00111);
            check($sformatf("boot%0d_pc", i), PC, RPC);
            step();
        end

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d_ctl", i), ctl_now(), tbl[i].ctl);
            step();
            check($sformatf("row%0d_pc", i), PC, tbl[i].pc);
        end
        check("table_redir", REDIRECT_CNT, 5);
        check("table_stall", STALL_CNT, 0);

        // load-use against ber: two bubbles, then ber resolves taken
        drive(mkv(0, 0, 8'h88, 0, OP_BER, 3, OP_LD, 3, NOP));
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("lu%0d_ctl", i), ctl_now(), 5'b00010);
            step();
            check($sformatf("lu%0d_pc", i), PC, 8'h01);
        end
        check("lu_stallcnt", STALL_CNT, 2);
        drive(mkv(0, 1, 8'h88, 0, OP_BER, 3, NOP, 3, NOP));
        #1;
        check("lu_res_ctl", ctl_now(), 5'b11100);
        step();
        check("lu_res_pc", PC, 8'h88);
        check("lu_res_redir", REDIRECT_CNT, 6);

        // MEM redirect during STALL abandons the stall
        drive(mkv(0, 0, 0, 8'h21, OP_JR, 1, OP_LD, 1, NOP));
        step();
        drive(mkv(0, 2, 0, 8'h21, OP_JR, 1, OP_LD, 1, OP_J));
        #1;
        check("abandon_ctl", ctl_now(), 5'b11111);
        step();
        check("abandon_pc", PC, 8'h21);
        drive(mkv(0, 0, 0, 0, NOP, 0, NOP, 0, NOP));
        #1;
        check("abandon_run_ctl", ctl_now(), 5'b11000);
        step();
        check("abandon_run_pc", PC, 8'h22);
        check("abandon_stall", STALL_CNT, 3);
        check("abandon_redir", REDIRECT_CNT, 7);

        // HOLD at FF then wrap to 00
        drive(mkv(0, 2, 0, 8'hFF, NOP, 0, NOP, 0, OP_J));
        step();
        drive(mkv(1, 0, 0, 0, NOP, 0, NOP, 0, NOP));
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d_ctl", i), ctl_now(), 5'b00000);
            step();
            check($sformatf("hold%0d_pc", i), PC, 8'hFF);
        end
        check("hold_redir", REDIRECT_CNT, 8);
        check("hold_stall", STALL_CNT, 3);
        HOLD = 1'b0;
        step();
        check("wrap_pc", PC, 8'h00);

        // async reset in the second stall cycle
        drive(mkv(0, 0, 0, 0, OP_BNER, 2, OP_LD, 2, NOP));
        step();
        #1;
        RST = 1'b1;
        #1;
        check("rst_mid_pc", PC, RPC);
        check("rst_mid_stall", STALL_CNT, 0);
        check("rst_mid_redir", REDIRECT_CNT, 0);
        check("rst_mid_ctl", ctl_now(), 5'b00111);

        // randomized run against the model
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            HOLD           = ($urandom_range(0, 7) == 0);
            SEL            = 2'($urandom_range(0, 3));
            BRANCH_ADDR    = 8'($urandom);
            JUMP_ADDR      = 8'($urandom);
            IFID_OPCODE    = POOL[$urandom_range(0, 7)];
            IDEX_OPCODE    = POOL[$urandom_range(0, 7)];
            EXMEM_OPCODE   = POOL[$urandom_range(0, 7)];
            IFID_SRC_ADDR  = 4'($urandom_range(0, 1));
            IDEX_DEST_ADDR = 4'($urandom_range(0, 1));
            #1;
            model_eval();
            check("rnd_ctl", ctl_now(), e_ctl);
            check("rnd_pc", PC, m_pc);
            check("rnd_redir", REDIRECT_CNT, m_redir);
            check("rnd_stall", STALL_CNT, m_stall);
            @(posedge CLK);
            model_commit();
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
